// File: rtl/clock_768k_clk_monitor_if.sv
// clock_768k_clk_monitor_if: PLL clock input and verified-lock status bundle
interface clock_768k_clk_monitor_if #(
  parameter int CNT_W = 16
);
  logic             clk_in;
  logic             pll_locked;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             freq_ok;
  logic             too_fast;
  logic             too_slow;
  logic             stuck;
  logic             mon_locked;
  modport master (
    output clk_in, pll_locked,
    input  edge_count, count_valid, freq_ok, too_fast, too_slow, stuck, mon_locked
  );
  modport slave (
    input  clk_in, pll_locked,
    output edge_count, count_valid, freq_ok, too_fast, too_slow, stuck, mon_locked
  );
endinterface

// File: rtl/clock_768k_clk_monitor.sv
// clock_768k_clk_monitor: gated edge-count frequency checker producing a verified-lock status
module clock_768k_clk_monitor #(
  parameter int GATE_CYCLES  = 100000,
  parameter int EXPECT_COUNT = 1536,
  parameter int TOL          = 4,
  parameter int GOOD_WINDOWS = 3,
  parameter int STUCK_CYCLES = 256,
  parameter int CNT_W        = 16
) (
  input logic refclk,
  input logic rst,
  clock_768k_clk_monitor_if.slave mon
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam int BW = $clog2(GOOD_WINDOWS + 1);
  localparam int unsigned LO = (EXPECT_COUNT > TOL) ? EXPECT_COUNT - TOL : 0;
  localparam int unsigned HI = EXPECT_COUNT + TOL;
  typedef enum logic [1:0] {WAIT_LOCK, MEASURE, LOCKED} state_t;
  state_t state, state_n;
  logic s1, s2, s3, l1, l2;
  logic rise, run, win_end, stuck, slow, fast, in_range, leave, enter;
  logic [GW-1:0] gcnt;
  logic [CNT_W-1:0] ecnt, win_cnt;
  logic [SW-1:0] scnt;
  logic [BW-1:0] good_cnt;
  // edge detect, window/range qualification and next-state; pll_locked loss wins over everything
  always_comb begin
    rise = s2 & ~s3;
    run = l2 && state != WAIT_LOCK;
    win_end = run && gcnt == GW'(GATE_CYCLES - 1);
    win_cnt = (rise && ~&ecnt) ? ecnt + 1'b1 : ecnt;
    slow = 32'(win_cnt) < LO;
    fast = 32'(win_cnt) > HI;
    in_range = !slow && !fast;
    stuck = scnt == SW'(STUCK_CYCLES);
    leave = state == LOCKED && ((win_end && !in_range) || stuck);
    enter = state == MEASURE && win_end && in_range && !stuck && good_cnt == BW'(GOOD_WINDOWS - 1);
    state_n = !l2 ? WAIT_LOCK :
              state == WAIT_LOCK ? MEASURE :
              leave ? MEASURE :
              enter ? LOCKED : state;
  end
  // state register
  always_ff @(posedge refclk) begin
    if (rst) state <= WAIT_LOCK;
    else state <= state_n;
  end
  // synchronisers for the asynchronous clock and lock inputs
  always_ff @(posedge refclk) begin
    if (rst) {s1, s2, s3, l1, l2} <= '0;
    else begin
      s1 <= mon.clk_in;
      s2 <= s1;
      s3 <= s2;
      l1 <= mon.pll_locked;
      l2 <= l1;
    end
  end
  // gate and edge counters, held at zero whenever not measuring so a fresh window starts on entry
  always_ff @(posedge refclk) begin
    if (rst || !run) begin
      gcnt <= '0;
      ecnt <= '0;
    end else begin
      gcnt <= win_end ? '0 : gcnt + 1'b1;
      ecnt <= win_end ? '0 : win_cnt;
    end
  end
  // stuck counter saturates at the threshold and restarts on every edge
  always_ff @(posedge refclk) begin
    if (rst) scnt <= '0;
    else scnt <= rise ? '0 : stuck ? scnt : scnt + 1'b1;
  end
  // window results and consecutive good-window tally
  always_ff @(posedge refclk) begin
    if (rst) begin
      mon.edge_count <= '0;
      mon.count_valid <= 1'b0;
      mon.freq_ok <= 1'b0;
      mon.too_fast <= 1'b0;
      mon.too_slow <= 1'b0;
      good_cnt <= '0;
    end else begin
      mon.count_valid <= win_end;
      if (win_end) begin
        mon.edge_count <= win_cnt;
        mon.freq_ok <= in_range;
        mon.too_fast <= fast;
        mon.too_slow <= slow;
      end else if (!l2) mon.freq_ok <= 1'b0;
      good_cnt <= state_n != MEASURE ? '0 :
                  (win_end && state == MEASURE) ? (in_range ? good_cnt + 1'b1 : '0) : good_cnt;
    end
  end
  assign mon.stuck = stuck;
  assign mon.mon_locked = state == LOCKED;
endmodule

// File: tb/tb_clock_768k_clk_monitor.sv
// tb_clock_768k_clk_monitor: scoreboard bench with scaled-down windows
module tb_clock_768k_clk_monitor;
  localparam int GATE = 200;
  localparam int EXPC = 20;
  localparam int TOLR = 1;
  localparam int GOOD = 3;
  localparam int STK  = 32;
  localparam int WIN_LAT = GATE + 3;
  typedef struct {int lo; int hi; int cls; bit lock;} exp_t;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int period = 10;
  int last_rise = 0;
  clock_768k_clk_monitor_if #(.CNT_W(16)) bus();
  clock_768k_clk_monitor #(
    .GATE_CYCLES(GATE), .EXPECT_COUNT(EXPC), .TOL(TOLR),
    .GOOD_WINDOWS(GOOD), .STUCK_CYCLES(STK), .CNT_W(16)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .mon(bus)
  );
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // period in refclk cycles: 10 nominal (20 edges/window), 8 fast (25), 12 slow (16-17), 0 stopped
  task automatic push(input int p, input bit lock);
    exp_t e;
    e.lo = p == 10 ? 19 : p == 8 ? 24 : p == 12 ? 16 : 0;
    e.hi = p == 10 ? 21 : p == 8 ? 26 : p == 12 ? 18 : 1;
    e.cls = p == 10 ? 0 : p == 8 ? 1 : 2;
    e.lock = lock;
    q.push_back(e);
  endtask
  task automatic wait_cv(output int at);
    at = -1;
    for (int i = 0; i < 2 * GATE; i++) begin
      @(negedge refclk);
      if (bus.count_valid) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL count_valid_timeout: got none expected pulse within %0d cycles", 2 * GATE);
  endtask
  task automatic win(input int p, input bit lock);
    int t;
    period = p;
    push(p, lock);
    wait_cv(t);
  endtask
  initial begin
    int ph;
    ph = 0;
    bus.clk_in = 1'b0;
    forever begin
      @(posedge refclk);
      #2;
      if (period == 0) begin
        bus.clk_in = 1'b0;
        ph = 0;
      end else begin
        ph = (ph + 1 >= period) ? 0 : ph + 1;
        if (ph < period / 2 && !bus.clk_in) last_rise = cyc;
        bus.clk_in = ph < period / 2;
      end
    end
  end
  always @(negedge refclk) begin
    if (bus.count_valid) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got edge_count %0d expected no count_valid", bus.edge_count);
      end else begin
        e = q.pop_front();
        checks++;
        if (int'(bus.edge_count) < e.lo || int'(bus.edge_count) > e.hi) begin
          errors++;
          $display("FAIL edge_count: got %0d expected %0d..%0d", bus.edge_count, e.lo, e.hi);
        end
        chk("freq_ok", bus.freq_ok, e.cls == 0);
        chk("too_fast", bus.too_fast, e.cls == 1);
        chk("too_slow", bus.too_slow, e.cls == 2);
        chk("mon_locked_at_window", bus.mon_locked, e.lock);
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int t, t0;
    bus.pll_locked = 1'b1;
    repeat (4) @(negedge refclk);
    chk("rst_edge_count", bus.edge_count, 0);
    chk("rst_count_valid", bus.count_valid, 0);
    chk("rst_freq_ok", bus.freq_ok, 0);
    chk("rst_too_fast", bus.too_fast, 0);
    chk("rst_too_slow", bus.too_slow, 0);
    chk("rst_stuck", bus.stuck, 0);
    chk("rst_mon_locked", bus.mon_locked, 0);
    rst = 1'b0;
    win(10, 0);
    win(10, 0);
    win(10, 1);
    win(10, 1);
    period = 0;
    push(0, 0);
    for (int i = 0; i < 3 * STK && !bus.stuck; i++) @(negedge refclk);
    chk("stuck_asserts", bus.stuck, 1);
    chk("stuck_delay", cyc - last_rise, STK + 3);
    chk("locked_when_stuck", bus.mon_locked, 1);
    @(negedge refclk);
    chk("locked_drop_after_stuck", bus.mon_locked, 0);
    wait_cv(t);
    period = 10;
    push(10, 0);
    for (int i = 0; i < 50 && bus.stuck; i++) @(negedge refclk);
    chk("stuck_clears", bus.stuck, 0);
    chk("stuck_clear_delay", cyc - last_rise, 3);
    wait_cv(t);
    win(10, 0);
    win(10, 1);
    repeat (50) @(negedge refclk);
    bus.pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    chk("locked_before_sync", bus.mon_locked, 1);
    @(negedge refclk);
    chk("locked_after_pll_drop", bus.mon_locked, 0);
    chk("freq_ok_after_pll_drop", bus.freq_ok, 0);
    chk("edge_count_held", bus.edge_count, EXPC);
    repeat (7) @(negedge refclk);
    bus.pll_locked = 1'b1;
    t0 = cyc;
    push(10, 0);
    wait_cv(t);
    chk("relock_window_latency", t - t0, WIN_LAT);
    win(10, 0);
    win(10, 1);
    repeat (60) @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    chk("midrst_edge_count", bus.edge_count, 0);
    chk("midrst_freq_ok", bus.freq_ok, 0);
    chk("midrst_mon_locked", bus.mon_locked, 0);
    chk("midrst_count_valid", bus.count_valid, 0);
    t0 = cyc;
    push(10, 0);
    wait_cv(t);
    chk("reset_window_latency", t - t0, WIN_LAT);
    win(8, 0);
    win(8, 0);
    win(8, 0);
    win(10, 0);
    win(12, 0);
    win(10, 0);
    win(12, 0);
    repeat (20) @(negedge refclk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
